// File: rtl/jk_sync_counter_if.sv
// Control and status bundle for the JK-chained modulo-N counter.
interface jk_sync_counter_if #(
    parameter int unsigned WIDTH = 4
);
    logic             en;
    logic             up_dn;
    logic             load;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] qb;
    logic             tc;
    logic             wrap;

    // Controller side: drives the controls and observes the count.
    modport master (
        output en, up_dn, load, din,
        input  q, qb, tc, wrap
    );

    // Counter side: consumes the controls and drives the count.
    modport slave (
        input  en, up_dn, load, din,
        output q, qb, tc, wrap
    );
endinterface

// File: rtl/jk_sync_counter.sv
// Synchronous modulo-MOD up/down counter built from chained JK toggle stages,
// with parallel load (saturating), terminal count and a sticky wrap flag.
module jk_sync_counter #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned MOD   = 10
) (
    input logic              clk,
    input logic              rst,
    jk_sync_counter_if.slave bus
);
    localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MOD - 1);
    localparam logic [WIDTH:0]   MOD_W = (WIDTH + 1)'(MOD);

    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] qb_r;
    logic             wrap_r;
    logic [WIDTH-1:0] tog;
    logic [WIDTH-1:0] q_nxt;
    logic [WIDTH-1:0] din_sat;
    logic             in_range;
    logic             tc_c;

    // Per-bit JK toggle enable: a bit flips when every lower bit sits at the
    // carry (all ones, counting up) or borrow (all zeros, counting down) value.
    always_comb begin
        tog    = '0;
        tog[0] = 1'b1;
        for (int i = 1; i < int'(WIDTH); i++) begin
            tog[i] = tog[i-1] & (bus.up_dn ? q_r[i-1] : ~q_r[i-1]);
        end
    end

    // Range check, terminal count and load saturation.
    always_comb begin
        in_range = ({1'b0, q_r} < MOD_W);
        tc_c     = bus.en & ~bus.load & ~rst &
                   ((bus.up_dn & (q_r == MAX_Q)) | (~bus.up_dn & (q_r == '0)));
        din_sat  = ({1'b0, bus.din} >= MOD_W) ? MAX_Q : bus.din;
    end

    // Next count for a non-reset, non-load edge: recover an illegal state,
    // wrap at the terminal count, otherwise apply the JK toggles when enabled.
    always_comb begin
        q_nxt = q_r;
        if (!in_range) begin
            q_nxt = '0;
        end else if (tc_c) begin
            q_nxt = bus.up_dn ? '0 : MAX_Q;
        end else if (bus.en) begin
            q_nxt = q_r ^ tog;
        end
    end

    // State update; the complement is registered from the same next value so
    // it can never be out of step with the count.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_r    <= '0;
            qb_r   <= '1;
            wrap_r <= 1'b0;
        end else if (bus.load) begin
            q_r    <= din_sat;
            qb_r   <= ~din_sat;
            wrap_r <= 1'b0;
        end else begin
            q_r    <= q_nxt;
            qb_r   <= ~q_nxt;
            wrap_r <= wrap_r | tc_c;
        end
    end

    assign bus.q    = q_r;
    assign bus.qb   = qb_r;
    assign bus.tc   = tc_c;
    assign bus.wrap = wrap_r;
endmodule

// File: tb/tb_jk_sync_counter.sv
// Directed self-checking bench for the default decade configuration.
module tb_jk_sync_counter;
    localparam int unsigned WIDTH = 4;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_err;

    jk_sync_counter_if #(.WIDTH(WIDTH)) bus ();

    jk_sync_counter #(.WIDTH(WIDTH), .MOD(10)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count one comparison and report it if it differs.
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Check q, qb and wrap against a hand-computed expected count.
    task automatic chk_state(input string tag, input logic [3:0] eq, input logic ew);
        logic [3:0] eqb;
        eqb = ~eq;
        chk({tag, ".q"},    32'(bus.q),    32'(eq));
        chk({tag, ".qb"},   32'(bus.qb),   32'(eqb));
        chk({tag, ".wrap"}, 32'(bus.wrap), 32'(ew));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic l, input logic e, input logic u, input logic [3:0] d);
        rst       = r;
        bus.load  = l;
        bus.en    = e;
        bus.up_dn = u;
        bus.din   = d;
        #1;
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;

        // Reset then hold
        drive(1'b1, 1'b0, 1'b0, 1'b1, 4'd0);
        tick();
        chk_state("reset", 4'd0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 4'd0);
        chk("hold.tc", 32'(bus.tc), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_state("hold", 4'd0, 1'b0);
            chk("hold.tc", 32'(bus.tc), 32'd0);
        end

        // Up count through the 9 -> 0 wrap
        drive(1'b0, 1'b0, 1'b1, 1'b1, 4'd0);
        for (int k = 1; k <= 10; k++) begin
            chk("up.tc", 32'(bus.tc), 32'(k == 10));
            tick();
            chk_state("up", 4'(k % 10), 1'(k == 10));
        end
        tick();
        chk_state("up.sticky", 4'd1, 1'b1);

        // Down count through the 0 -> 9 wrap
        drive(1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
        chk("ld.tc", 32'(bus.tc), 32'd0);
        tick();
        chk_state("dn.load0", 4'd0, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
        chk("dn.tc0", 32'(bus.tc), 32'd1);
        tick();
        chk_state("dn.wrap", 4'd9, 1'b1);
        chk("dn.tc9", 32'(bus.tc), 32'd0);
        tick();
        chk_state("dn.8", 4'd8, 1'b1);
        tick();
        chk_state("dn.7", 4'd7, 1'b1);

        // Load clamps an out-of-range value and clears wrap
        drive(1'b0, 1'b1, 1'b1, 1'b1, 4'd12);
        tick();
        chk_state("ld.clamp", 4'd9, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 1'b1, 4'd5);
        tick();
        chk_state("ld.5", 4'd5, 1'b0);

        // Reset beats a simultaneous load
        drive(1'b0, 1'b1, 1'b0, 1'b1, 4'd6);
        tick();
        chk_state("rm.6", 4'd6, 1'b0);
        drive(1'b1, 1'b1, 1'b1, 1'b1, 4'd3);
        chk("rm.tc", 32'(bus.tc), 32'd0);
        tick();
        chk_state("rm.rst", 4'd0, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 1'b1, 4'd0);
        tick();
        chk_state("rm.1", 4'd1, 1'b0);
        tick();
        chk_state("rm.2", 4'd2, 1'b0);

        // Direction change takes effect on the same edge
        drive(1'b0, 1'b1, 1'b0, 1'b1, 4'd3);
        tick();
        chk_state("df.3", 4'd3, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 1'b1, 4'd0);
        tick();
        chk_state("df.4", 4'd4, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
        tick();
        chk_state("df.3b", 4'd3, 1'b0);
        tick();
        chk_state("df.2", 4'd2, 1'b0);

        // Up-direction at zero is not terminal; hold keeps the count
        drive(1'b0, 1'b1, 1'b0, 1'b1, 4'd0);
        tick();
        drive(1'b0, 1'b0, 1'b1, 1'b1, 4'd0);
        chk("up0.tc", 32'(bus.tc), 32'd0);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 4'd0);
        tick();
        chk_state("hold0", 4'd0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
